// File: rtl/tm1638_key_events.sv
// TM1638 key-scan debouncer with press/release event FIFO.
// Optional KEY_EVENT_TIMESTAMP_EN adds a per-event scan-count stamp (evt_scan).
module tm1638_key_events #(
    parameter int NUM_KEYS       = 8,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            scan_valid,
    input  logic [31:0]                     scan_data,
    output logic [7:0]                      keys_stable,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [2:0]                      evt_key,
    output logic                            evt_pressed,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] evt_count,
    output logic                            overflow,
    input  logic                            clear_overflow
`ifdef KEY_EVENT_TIMESTAMP_EN
    ,
    output logic [15:0]                     evt_scan
`endif
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int KW = $clog2(NUM_KEYS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic [NUM_KEYS-1:0] raw;
    logic [NUM_KEYS-1:0] set_mask;
    logic [NUM_KEYS-1:0] clr_mask;
    logic [NUM_KEYS-1:0] pending;
    logic [CW-1:0]       cnt [NUM_KEYS];
    logic [KW-1:0]       sel;
    logic                unused_scan_bits;

    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [KW-1:0] key_mem [FIFO_DEPTH];
    logic          prs_mem [FIFO_DEPTH];

    // Keys 0-3 sit on bit 0 and keys 4-7 on bit 4 of scan bytes 0-3
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            raw[i]     = scan_data[8*i];
            raw[4 + i] = scan_data[8*i + 4];
        end
    end

    assign unused_scan_bits = ^(scan_data & ~32'h1111_1111);

    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            set_mask[k] = scan_valid && (raw[k] != keys_stable[k])
                          && (cnt[k] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_stable <= '0;
            for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
        end else if (scan_valid) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (raw[k] == keys_stable[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    keys_stable[k] <= raw[k];
                    cnt[k]         <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CW'(1);
                end
            end
        end
    end

    // Lowest pending index wins; a same-cycle re-set keeps the bit alive
    always_comb begin
        sel = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pending[k]) sel = KW'(k);
        end
        clr_mask = NUM_KEYS'(|pending) << sel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending <= '0;
        else       pending <= (pending & ~clr_mask) | set_mask;
    end

    assign push  = |pending;
    assign pop   = evt_valid && evt_ready;
    assign full  = (evt_count == NW'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_mem[wr_ptr] <= sel;
            prs_mem[wr_ptr] <= keys_stable[sel];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !pop)      evt_count <= evt_count + NW'(1);
            else if (!wr_en && pop) evt_count <= evt_count - NW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               overflow <= 1'b0;
        else if (clear_overflow) overflow <= 1'b0;
        else if (drop)           overflow <= 1'b1;
    end

    assign evt_valid   = (evt_count != '0);
    assign evt_key     = evt_valid ? 3'(key_mem[rd_ptr]) : 3'd0;
    assign evt_pressed = evt_valid ? prs_mem[rd_ptr] : 1'b0;

`ifdef KEY_EVENT_TIMESTAMP_EN
    logic [15:0] scan_cnt;
    logic [15:0] ts_pend [NUM_KEYS];
    logic [15:0] ts_mem  [FIFO_DEPTH];

    // Stamp is the count before the scan that completed the debounce
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            for (int k = 0; k < NUM_KEYS; k++) ts_pend[k] <= '0;
        end else begin
            if (scan_valid) scan_cnt <= scan_cnt + 16'd1;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (set_mask[k]) ts_pend[k] <= scan_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ts_mem[wr_ptr] <= ts_pend[sel];
    end

    assign evt_scan = evt_valid ? ts_mem[rd_ptr] : 16'd0;
`endif

endmodule
